// File: rtl/mole_scheduler.sv
// Whack-a-mole round scheduler: latches the level at start, then alternates
// gap and raised-mole phases, reporting hit/miss pulses and a saturating hit count.
module mole_scheduler #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int GAP_TICKS = 2,
  parameter int UP_T1     = 8,
  parameter int UP_T2     = 5,
  parameter int UP_T3     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] level,
  input  logic [3:0] btn,
  output logic [3:0] mole_active,
  output logic       hit,
  output logic       miss,
  output logic [7:0] hits,
  output logic       busy,
  output logic [1:0] dbg_state,
  output logic [7:0] dbg_lfsr
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GAP  = 2'd1;
  localparam logic [1:0] S_UP   = 2'd2;

  logic [1:0]       state;
  logic [1:0]       lvl_q;
  logic [7:0]       cnt;
  logic [DIV_W-1:0] div;
  logic [7:0]       lfsr;
  logic             tick;
  logic             lfsr_fb;
  logic             whack;
  logic [7:0]       up_ticks;
  logic [3:0]       next_mole;

  assign tick      = (div == DIV_LAST);
  assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign whack     = |(btn & mole_active);
  assign next_mole = 4'b0001 << lfsr[1:0];
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;
  assign dbg_lfsr  = lfsr;

  always_comb begin
    up_ticks = 8'(UP_T1);
    case (lvl_q)
      2'b10:   up_ticks = 8'(UP_T2);
      2'b11:   up_ticks = 8'(UP_T3);
      default: up_ticks = 8'(UP_T1);
    endcase
  end

  // start/stop/btn are single-cycle pulses sampled on the rising edge; there is
  // no backpressure, so every accepted pulse acts immediately on the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      lvl_q       <= 2'b00;
      cnt         <= 8'd0;
      div         <= '0;
      lfsr        <= 8'hA5;
      mole_active <= 4'b0000;
      hit         <= 1'b0;
      miss        <= 1'b0;
      hits        <= 8'd0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr_fb};
      hit  <= 1'b0;
      miss <= 1'b0;
      if (stop) begin
        state       <= S_IDLE;
        mole_active <= 4'b0000;
        cnt         <= 8'd0;
        div         <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && (level != 2'b00)) begin
              lvl_q <= level;
              hits  <= 8'd0;
              cnt   <= 8'(GAP_TICKS);
              div   <= '0;
              state <= S_GAP;
            end
          end
          S_GAP: begin
            if (tick) begin
              div <= '0;
              if (cnt == 8'd1) begin
                mole_active <= next_mole;
                cnt         <= up_ticks;
                state       <= S_UP;
              end else begin
                cnt <= cnt - 8'd1;
              end
            end else begin
              div <= div + 1'b1;
            end
          end
          S_UP: begin
            // A correct whack outranks expiry landing on the same edge.
            if (whack) begin
              hit         <= 1'b1;
              hits        <= (hits == 8'hFF) ? hits : hits + 8'd1;
              mole_active <= 4'b0000;
              cnt         <= 8'(GAP_TICKS);
              div         <= '0;
              state       <= S_GAP;
            end else if (tick && (cnt == 8'd1)) begin
              miss        <= 1'b1;
              mole_active <= 4'b0000;
              cnt         <= 8'(GAP_TICKS);
              div         <= '0;
              state       <= S_GAP;
            end else if (tick) begin
              cnt <= cnt - 8'd1;
              div <= '0;
            end else begin
              div <= div + 1'b1;
            end
          end
          default: begin
            state       <= S_IDLE;
            mole_active <= 4'b0000;
            div         <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mole_scheduler.sv
// Bench for mole_scheduler with TICK_DIV=4: a reference lfsr predicts moles and
// a queue of expected hit/miss pulses is checked whenever the DUT emits one.
module tb_mole_scheduler;

  localparam int TICK_DIV = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic [1:0] level = 2'b00;
  logic [3:0] btn   = 4'b0000;
  logic [3:0] mole_active;
  logic       hit;
  logic       miss;
  logic [7:0] hits;
  logic       busy;
  logic [1:0] dbg_state;
  logic [7:0] dbg_lfsr;

  logic [7:0] m_lfsr;
  logic [7:0] m_prev;
  logic [9:0] exp_q[$];
  logic [7:0] exp_hits;
  int tests = 0;
  int fails = 0;

  mole_scheduler #(.TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .level(level),
    .btn(btn), .mole_active(mole_active), .hit(hit), .miss(miss),
    .hits(hits), .busy(busy), .dbg_state(dbg_state), .dbg_lfsr(dbg_lfsr)
  );

  always #5 clk = ~clk;

  // Reference lfsr; m_prev holds the value seen by the most recent edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= 8'hA5;
      m_prev <= 8'hA5;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  function automatic logic [3:0] onehot(input logic [1:0] i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  task automatic cycle();
    logic [9:0] e;
    @(negedge clk);
    if (rst_n && (hit || miss)) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pulse_unexpected: got hit=%0b miss=%0b hits=%0d, required no pulse", hit, miss, hits);
      end else begin
        e = exp_q.pop_front();
        if ({hit, miss, hits} !== e) begin
          fails++;
          $display("FAIL pulse: got hit=%0b miss=%0b hits=%0d, required hit=%0b miss=%0b hits=%0d",
                   hit, miss, hits, e[9], e[8], e[7:0]);
        end
      end
    end
  endtask

  task automatic wait_mole(input int max, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (mole_active == 4'b0000 && n < max);
  endtask

  task automatic start_game(input logic [1:0] lv);
    level = lv;
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic stop_game();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
  endtask

  task automatic hit_round();
    int n;
    logic [3:0] m;
    wait_mole(40, n);
    m = onehot(m_prev[1:0]);
    tests++;
    if (n != 8 || mole_active !== m) begin
      fails++;
      $display("FAIL round_rise: got gap=%0d mole=%b, required gap=8 mole=%b", n, mole_active, m);
    end
    exp_hits = (exp_hits == 8'hFF) ? exp_hits : exp_hits + 8'd1;
    exp_q.push_back({1'b1, 1'b0, exp_hits});
    btn = mole_active;
    cycle();
    btn = 4'b0000;
    tests++;
    if (mole_active !== 4'b0000) begin
      fails++;
      $display("FAIL round_clear: got mole=%b, required 0000", mole_active);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({mole_active, hit, miss, hits, busy} !== 15'd0) begin
      fails++;
      $display("FAIL reset_outputs: got mole=%b hit=%b miss=%b hits=%0d busy=%b, required all 0",
               mole_active, hit, miss, hits, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (dbg_lfsr !== 8'hA5 || dbg_state !== 2'd0) begin
      fails++;
      $display("FAIL reset_seed: got lfsr=%h state=%0d, required lfsr=a5 state=0", dbg_lfsr, dbg_state);
    end
    repeat (3) cycle();
    tests++;
    if (dbg_lfsr !== m_lfsr) begin
      fails++;
      $display("FAIL lfsr_seq: got %h, required %h", dbg_lfsr, m_lfsr);
    end
  endtask

  task automatic test_no_level();
    int bad;
    bad = 0;
    start_game(2'b00);
    for (int i = 0; i < 50; i++) begin
      if (busy !== 1'b0 || mole_active !== 4'b0000) bad++;
      cycle();
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL level00_start: got %0d busy/mole cycles, required 0", bad);
    end
    level = 2'b11;
    start = 1'b1;
    stop  = 1'b1;
    cycle();
    start = 1'b0;
    stop  = 1'b0;
    repeat (10) cycle();
    tests++;
    if (busy !== 1'b0 || mole_active !== 4'b0000) begin
      fails++;
      $display("FAIL stop_beats_start: got busy=%b mole=%b, required busy=0 mole=0000", busy, mole_active);
    end
  endtask

  task automatic test_miss();
    int n;
    int up_n;
    logic [3:0] m;
    start_game(2'b11);
    exp_hits = 8'd0;
    tests++;
    if (busy !== 1'b1 || mole_active !== 4'b0000) begin
      fails++;
      $display("FAIL miss_start: got busy=%b mole=%b, required busy=1 mole=0000", busy, mole_active);
    end
    wait_mole(40, n);
    m = onehot(m_prev[1:0]);
    tests++;
    if (n != 8 || mole_active !== m) begin
      fails++;
      $display("FAIL miss_rise: got gap=%0d mole=%b, required gap=8 mole=%b", n, mole_active, m);
    end
    exp_q.push_back({1'b0, 1'b1, 8'd0});
    up_n = 1;
    while (mole_active != 4'b0000 && up_n < 60) begin
      cycle();
      if (mole_active != 4'b0000) up_n++;
    end
    tests++;
    if (up_n != 12 || miss !== 1'b1 || hits !== 8'd0) begin
      fails++;
      $display("FAIL miss_timing: got up=%0d miss=%b hits=%0d, required up=12 miss=1 hits=0", up_n, miss, hits);
    end
    cycle();
    tests++;
    if (miss !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL miss_pulse_width: got miss=%b busy=%b, required miss=0 busy=1", miss, busy);
    end
    stop_game();
  endtask

  task automatic test_hit();
    int n;
    logic [3:0] m;
    start_game(2'b01);
    exp_hits = 8'd0;
    wait_mole(40, n);
    m = mole_active;
    tests++;
    if (n != 8 || m !== onehot(m_prev[1:0])) begin
      fails++;
      $display("FAIL hit_rise: got gap=%0d mole=%b, required gap=8 mole=%b", n, m, onehot(m_prev[1:0]));
    end
    btn = {m[2:0], m[3]};
    cycle();
    btn = 4'b0000;
    tests++;
    if (mole_active !== m || hit !== 1'b0 || miss !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL wrong_btn: got mole=%b hit=%b miss=%b busy=%b, required mole=%b hit=0 miss=0 busy=1",
               mole_active, hit, miss, busy, m);
    end
    repeat (3) cycle();
    exp_q.push_back({1'b1, 1'b0, 8'd1});
    btn = m;
    cycle();
    btn = 4'b0000;
    tests++;
    if (hit !== 1'b1 || mole_active !== 4'b0000 || hits !== 8'd1) begin
      fails++;
      $display("FAIL hit_result: got hit=%b mole=%b hits=%0d, required hit=1 mole=0000 hits=1", hit, mole_active, hits);
    end
    wait_mole(40, n);
    tests++;
    if (n != 8 || mole_active === 4'b0000) begin
      fails++;
      $display("FAIL hit_next_gap: got gap=%0d mole=%b, required gap=8 and a raised mole", n, mole_active);
    end
    stop_game();
    tests++;
    if (busy !== 1'b0 || hits !== 8'd1) begin
      fails++;
      $display("FAIL hit_stop: got busy=%b hits=%0d, required busy=0 hits=1", busy, hits);
    end
  endtask

  task automatic test_level_latch();
    int n;
    int bad;
    logic [3:0] m;
    start_game(2'b10);
    level = 2'b11;
    wait_mole(40, n);
    m = mole_active;
    bad = 0;
    for (int i = 1; i < 20; i++) begin
      cycle();
      if (mole_active !== m) bad++;
    end
    tests++;
    if (n != 8 || bad != 0) begin
      fails++;
      $display("FAIL latch_up_len: got gap=%0d early-drop cycles=%0d, required gap=8 drops=0", n, bad);
    end
    exp_q.push_back({1'b1, 1'b0, 8'd1});
    btn = m;
    cycle();
    btn = 4'b0000;
    tests++;
    if (hit !== 1'b1 || miss !== 1'b0 || mole_active !== 4'b0000) begin
      fails++;
      $display("FAIL hit_on_expiry: got hit=%b miss=%b mole=%b, required hit=1 miss=0 mole=0000", hit, miss, mole_active);
    end
    cycle();
    tests++;
    if (miss !== 1'b0) begin
      fails++;
      $display("FAIL late_miss: got miss=%b, required 0", miss);
    end
    stop_game();
  endtask

  task automatic test_stop_and_sat();
    int n;
    start_game(2'b11);
    exp_hits = 8'd0;
    repeat (3) hit_round();
    wait_mole(40, n);
    stop_game();
    tests++;
    if (busy !== 1'b0 || mole_active !== 4'b0000 || hits !== 8'd3 || hit !== 1'b0 || miss !== 1'b0) begin
      fails++;
      $display("FAIL stop_up: got busy=%b mole=%b hits=%0d hit=%b miss=%b, required busy=0 mole=0000 hits=3 no pulse",
               busy, mole_active, hits, hit, miss);
    end
    start_game(2'b11);
    exp_hits = 8'd0;
    tests++;
    if (hits !== 8'd0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL restart_clear: got hits=%0d busy=%b, required hits=0 busy=1", hits, busy);
    end
    repeat (257) hit_round();
    tests++;
    if (hits !== 8'd255) begin
      fails++;
      $display("FAIL hits_saturate: got %0d, required 255", hits);
    end
    stop_game();
  endtask

  task automatic test_async_reset();
    int n;
    start_game(2'b11);
    exp_hits = 8'd0;
    hit_round();
    wait_mole(40, n);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({mole_active, hit, miss, hits, busy} !== 15'd0) begin
      fails++;
      $display("FAIL async_reset: got mole=%b hit=%b miss=%b hits=%0d busy=%b, required all 0",
               mole_active, hit, miss, hits, busy);
    end
    cycle();
    rst_n = 1'b1;
    #1;
    tests++;
    if (dbg_lfsr !== 8'hA5 || busy !== 1'b0) begin
      fails++;
      $display("FAIL async_reseed: got lfsr=%h busy=%b, required lfsr=a5 busy=0", dbg_lfsr, busy);
    end
    repeat (2) cycle();
    tests++;
    if (dbg_lfsr !== m_lfsr) begin
      fails++;
      $display("FAIL async_lfsr_seq: got %h, required %h", dbg_lfsr, m_lfsr);
    end
  endtask

  initial begin
    test_reset();
    test_no_level();
    test_miss();
    test_hit();
    test_level_latch();
    test_stop_and_sat();
    test_async_reset();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending pulses, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
